sweep_sequencer: RTL

Calibration controller for the solar tracker's two servo channels, horizontal and vertical, each driven by a pwm_control instance. On START it sweeps the horizontal servo CCW from 0 to 180 deg, recording the pulse width at peak irradiance. It then parks the servo at that peak and repeats the sweep for the vertical servo. It generates DIR/EN/ES/MC for both channels and supplies pulseWidth_max to each.

---
 rtl/sweep_sequencer.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sweep_sequencer.sv
// Two-axis servo calibration sequencer: sweeps the horizontal then the vertical
// channel, tracking the pulse width of peak irradiance and parking each axis there.
module sweep_sequencer #(
  parameter logic [31:0] MIN_PW         = 32'd500,
  parameter logic [31:0] END_PW         = 32'd2500,
  parameter logic [31:0] SETTLE_CYCLES  = 32'd100000000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter int unsigned LW             = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [LW-1:0] LIGHT,
  input  logic          LIGHT_VALID,
  input  logic [31:0]   PW_H,
  input  logic [31:0]   PW_V,
  output logic [1:0]    DIR_H,
  output logic [1:0]    DIR_V,
  output logic          EN_H,
  output logic          EN_V,
  output logic          ES_H,
  output logic          ES_V,
  output logic          MC_H,
  output logic          MC_V,
  output logic [31:0]   PWMAX_H,
  output logic [31:0]   PWMAX_V,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HSWEEP,
    S_HHOLD,
    S_VSWEEP,
    S_VHOLD,
    S_FINISH
  } state_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;
  localparam logic [1:0] DIR_CW   = 2'b10;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [LW-1:0] best_q, best_d;
  logic [31:0]   pwmax_h_q, pwmax_h_d;
  logic [31:0]   pwmax_v_q, pwmax_v_d;
  logic [1:0]    dir_h_q, dir_h_d;
  logic [1:0]    dir_v_q, dir_v_d;
  logic          en_h_q, en_h_d;
  logic          en_v_q, en_v_d;
  logic          es_h_q, es_h_d;
  logic          es_v_q, es_v_d;
  logic          mc_h_q, mc_h_d;
  logic          mc_v_q, mc_v_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          new_peak;

  assign new_peak = LIGHT_VALID && (LIGHT > best_q);

  // Next-state, counter and peak tracking
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    best_d    = best_q;
    pwmax_h_d = pwmax_h_q;
    pwmax_v_d = pwmax_v_q;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d   = S_HSWEEP;
          best_d    = '0;
          pwmax_h_d = MIN_PW;
          cnt_d     = '0;
        end
      end

      S_HSWEEP: begin
        cnt_d = cnt_q + 32'd1;
        if (new_peak) begin
          best_d    = LIGHT;
          pwmax_h_d = PW_H;
        end
        if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (PW_H >= END_PW) begin
          state_d = S_HHOLD;
          cnt_d   = '0;
        end
      end

      S_HHOLD: begin
        if (cnt_q == SETTLE_CYCLES - 32'd1) begin
          state_d   = S_VSWEEP;
          best_d    = '0;
          pwmax_v_d = MIN_PW;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_VSWEEP: begin
        cnt_d = cnt_q + 32'd1;
        if (new_peak) begin
          best_d    = LIGHT;
          pwmax_v_d = PW_V;
        end
        if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (PW_V >= END_PW) begin
          state_d = S_VHOLD;
          cnt_d   = '0;
        end
      end

      S_VHOLD: begin
        if (cnt_q == SETTLE_CYCLES - 32'd1) begin
          state_d = S_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything and discards the sample seen in this cycle
    if (ABORT && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      err_d     = 1'b0;
      pwmax_h_d = pwmax_h_q;
      pwmax_v_d = pwmax_v_q;
    end

    if (state_d == S_IDLE) begin
      cnt_d  = '0;
      best_d = '0;
    end
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    dir_h_d = DIR_STOP;
    dir_v_d = DIR_STOP;
    en_h_d  = 1'b0;
    en_v_d  = 1'b0;
    es_h_d  = 1'b0;
    es_v_d  = 1'b0;
    mc_h_d  = 1'b0;
    mc_v_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_d)
      S_HSWEEP: begin
        dir_h_d = DIR_CCW;
        en_h_d  = 1'b1;
        es_h_d  = 1'b1;
        busy_d  = 1'b1;
      end
      S_HHOLD: begin
        dir_h_d = DIR_CW;
        en_h_d  = 1'b1;
        mc_h_d  = 1'b1;
        busy_d  = 1'b1;
      end
      S_VSWEEP: begin
        dir_v_d = DIR_CCW;
        en_v_d  = 1'b1;
        es_v_d  = 1'b1;
        busy_d  = 1'b1;
      end
      S_VHOLD: begin
        dir_v_d = DIR_CW;
        en_v_d  = 1'b1;
        mc_v_d  = 1'b1;
        busy_d  = 1'b1;
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      best_q    <= '0;
      pwmax_h_q <= MIN_PW;
      pwmax_v_q <= MIN_PW;
      dir_h_q   <= DIR_STOP;
      dir_v_q   <= DIR_STOP;
      en_h_q    <= 1'b0;
      en_v_q    <= 1'b0;
      es_h_q    <= 1'b0;
      es_v_q    <= 1'b0;
      mc_h_q    <= 1'b0;
      mc_v_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      best_q    <= best_d;
      pwmax_h_q <= pwmax_h_d;
      pwmax_v_q <= pwmax_v_d;
      dir_h_q   <= dir_h_d;
      dir_v_q   <= dir_v_d;
      en_h_q    <= en_h_d;
      en_v_q    <= en_v_d;
      es_h_q    <= es_h_d;
      es_v_q    <= es_v_d;
      mc_h_q    <= mc_h_d;
      mc_v_q    <= mc_v_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign DIR_H   = dir_h_q;
  assign DIR_V   = dir_v_q;
  assign EN_H    = en_h_q;
  assign EN_V    = en_v_q;
  assign ES_H    = es_h_q;
  assign ES_V    = es_v_q;
  assign MC_H    = mc_h_q;
  assign MC_V    = mc_v_q;
  assign PWMAX_H = pwmax_h_q;
  assign PWMAX_V = pwmax_v_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule
